// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory with 1-cycle read latency.
// CPU has default priority; a saturating starvation counter forces an IO grant.
module dmem_arbiter #(
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 32,
    parameter int IO_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_gnt,
    output logic              io_rvalid,
    output logic [DATA_W-1:0] io_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        io_wait_dbg,
    output logic [1:0]        rd_owner_dbg
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_IO   = 2'd2
    } owner_e;

    localparam logic [3:0] MAX_WAIT = 4'(IO_MAX_WAIT);

    owner_e     rd_owner_q, rd_owner_d;
    logic [3:0] io_wait_q, io_wait_d;
    logic       io_force;
    logic       io_win;
    logic       cpu_win;

    // Grants are suppressed during reset, so a request seen with rst high never issues.
    always_comb begin
        io_force = (io_wait_q == MAX_WAIT);
        io_win   = !rst && io_req && (io_force || !cpu_req);
        cpu_win  = !rst && cpu_req && !io_win;
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (io_win) begin
            mem_en    = 1'b1;
            mem_we    = io_we;
            mem_addr  = io_addr;
            mem_wdata = io_wdata;
        end else if (cpu_win) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    always_comb begin
        rd_owner_d = OWN_NONE;
        if (io_win && !io_we) begin
            rd_owner_d = OWN_IO;
        end else if (cpu_win && !cpu_we) begin
            rd_owner_d = OWN_CPU;
        end

        io_wait_d = '0;
        if (io_req && !io_win) begin
            io_wait_d = (io_wait_q == MAX_WAIT) ? MAX_WAIT : io_wait_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_owner_q <= OWN_NONE;
            io_wait_q  <= '0;
        end else begin
            rd_owner_q <= rd_owner_d;
            io_wait_q  <= io_wait_d;
        end
    end

    always_comb begin
        cpu_gnt      = cpu_win;
        io_gnt       = io_win;
        cpu_rvalid   = (rd_owner_q == OWN_CPU);
        io_rvalid    = (rd_owner_q == OWN_IO);
        cpu_rdata    = cpu_rvalid ? mem_rdata : '0;
        io_rdata     = io_rvalid ? mem_rdata : '0;
        io_wait_dbg  = io_wait_q;
        rd_owner_dbg = rd_owner_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic, with a behavioural
// arbiter/memory model feeding an expected read-return queue checked by a monitor.
module tb_dmem_arbiter;
    localparam int ADDR_W      = 14;
    localparam int DATA_W      = 32;
    localparam int IO_MAX_WAIT = 4;
    localparam int W           = 16 + 2 + DATA_W;
    localparam int DEPTH       = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              io_req = 1'b0, io_we = 1'b0;
    logic [ADDR_W-1:0] io_addr = '0;
    logic [DATA_W-1:0] io_wdata = '0;
    logic              cpu_gnt, cpu_rvalid, io_gnt, io_rvalid;
    logic [DATA_W-1:0] cpu_rdata, io_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [3:0]        io_wait_dbg;
    logic [1:0]        rd_owner_dbg;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IO_MAX_WAIT(IO_MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .io_wait_dbg(io_wait_dbg), .rd_owner_dbg(rd_owner_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory attached to the DUT ----------------
    logic [DATA_W-1:0] mem    [DEPTH];
    logic [DATA_W-1:0] shadow [DEPTH];

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
        else                   mem_rdata <= $urandom;
    end

    // ---------------- scoreboard bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Owner codes in the queue: 1 = CPU, 2 = IO.
    int m_wait    = 0;
    bit m_cpu_gnt = 0;
    bit m_io_gnt  = 0;

    always @(negedge clk) begin
        bit e_io, e_cpu;
        e_io  = !rst && io_req && (m_wait >= IO_MAX_WAIT || !cpu_req);
        e_cpu = !rst && cpu_req && !e_io;

        chk("cpu_gnt", 64'(cpu_gnt), 64'(e_cpu));
        chk("io_gnt", 64'(io_gnt), 64'(e_io));
        chk("mem_en", 64'(mem_en), 64'(e_io || e_cpu));
        chk("mem_we", 64'(mem_we), 64'((e_io && io_we) || (e_cpu && cpu_we)));
        chk("mem_addr", 64'(mem_addr), e_io ? 64'(io_addr) : e_cpu ? 64'(cpu_addr) : 64'd0);
        chk("mem_wdata", 64'(mem_wdata), e_io ? 64'(io_wdata) : e_cpu ? 64'(cpu_wdata) : 64'd0);
        chk("io_wait", 64'(io_wait_dbg), 64'(m_wait));

        if (e_cpu && !cpu_we) exp_q.push_back({16'(cyc + 1), 2'd1, shadow[cpu_addr]});
        if (e_io  && !io_we)  exp_q.push_back({16'(cyc + 1), 2'd2, shadow[io_addr]});
        if (e_cpu && cpu_we)  shadow[cpu_addr] = cpu_wdata;
        if (e_io  && io_we)   shadow[io_addr]  = io_wdata;

        if (rst || !io_req || e_io) m_wait = 0;
        else if (m_wait < IO_MAX_WAIT) m_wait = m_wait + 1;
        m_cpu_gnt = e_cpu;
        m_io_gnt  = e_io;
    end

    // ---------------- read-return monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!cpu_rvalid) chk("cpu_rdata_idle", 64'(cpu_rdata), 64'd0);
        if (!io_rvalid)  chk("io_rdata_idle", 64'(io_rdata), 64'd0);
        if (cpu_rvalid || io_rvalid) begin
            if (exp_q.size() == 0 || exp_q[0][W-1:W-16] != 16'(cyc)) begin
                chk("unexpected_rvalid", {62'd0, io_rvalid, cpu_rvalid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rvalid_owner", {62'd0, io_rvalid, cpu_rvalid}, 64'(e[DATA_W+1:DATA_W]));
                chk("rdata", 64'(e[DATA_W-1:0]),
                    cpu_rvalid ? 64'(cpu_rdata) : 64'(io_rdata));
            end
        end else if (exp_q.size() != 0 && exp_q[0][W-1:W-16] <= 16'(cyc)) begin
            e = exp_q.pop_front();
            chk("missing_rvalid", 64'd0, 64'(e[DATA_W+1:DATA_W]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit r,
                         input bit cr, input bit cw, input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd,
                         input bit ir, input bit iw, input logic [ADDR_W-1:0] ia, input logic [DATA_W-1:0] id);
        @(posedge clk);
        #1;
        rst = r;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        io_req  = ir; io_we  = iw; io_addr  = ia; io_wdata  = id;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [ADDR_W-1:0] pick_addr();
        if ($urandom_range(0, 9) == 0) return 14'h3FFF;
        return 14'($urandom_range(0, 15));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]    = 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0000;
            shadow[i] = mem[i];
        end
        mem[14'h0010]    = 32'hDEAD_BEEF;
        shadow[14'h0010] = 32'hDEAD_BEEF;

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 14'h0010, 0, 1, 0, 14'h0020, 0);
        idle(1);

        // CPU-only read of the preloaded word
        drive(0, 1, 0, 14'h0010, 0, 0, 0, 0, 0);
        idle(1);
        #2 chk("dir_cpu_rdata", 64'(cpu_rdata), 64'hDEAD_BEEF);
        idle(1);

        // IO write then read-back of the top address
        drive(0, 0, 0, 0, 0, 1, 1, 14'h3FFF, 32'h1234_5678);
        drive(0, 0, 0, 0, 0, 1, 0, 14'h3FFF, 0);
        idle(1);
        #2 chk("dir_io_rdata", 64'(io_rdata), 64'h1234_5678);
        idle(1);

        // Continuous contention: IO forced on the 5th and 10th cycles
        for (int k = 0; k < 10; k++) begin
            drive(0, 1, 0, 14'h0010, 0, 1, 0, 14'h3FFF, 0);
            #2 chk("starve_io_gnt", 64'(io_gnt), 64'(k == 4 || k == 9));
        end
        idle(2);

        // Alternating CPU/IO reads, one per cycle
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) drive(0, 1, 0, 14'(k), 0, 0, 0, 0, 0);
            else            drive(0, 0, 0, 0, 0, 1, 0, 14'(k), 0);
        end
        idle(2);

        // Read granted, then reset arrives while CPU still requests
        drive(0, 1, 0, 14'h0005, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 14'h0006, 0, 1, 0, 14'h0007, 0);
        idle(2);

        // IO denied twice, drops, re-raises: needs four fresh denials
        drive(0, 1, 0, 14'h0001, 0, 1, 0, 14'h0002, 0);
        drive(0, 1, 0, 14'h0001, 0, 1, 0, 14'h0002, 0);
        drive(0, 1, 0, 14'h0001, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 0, 14'h0001, 0, 1, 0, 14'h0002, 0);
            #2 chk("restart_io_gnt", 64'(io_gnt), 64'(k == 4));
        end
        idle(2);

        // Random traffic honouring the hold-until-grant rule
        for (int n = 0; n < 3000; n++) begin
            bit c_pend, i_pend;
            @(posedge clk);
            #1;
            c_pend = cpu_req && !m_cpu_gnt;
            i_pend = io_req && !m_io_gnt;
            rst = ($urandom_range(0, 99) == 0);
            if (!c_pend) begin
                cpu_req   = ($urandom_range(0, 9) < 7);
                cpu_we    = ($urandom_range(0, 2) == 0);
                cpu_addr  = pick_addr();
                cpu_wdata = $urandom;
            end
            if (!i_pend) begin
                io_req   = ($urandom_range(0, 9) < 6);
                io_we    = ($urandom_range(0, 2) == 0);
                io_addr  = pick_addr();
                io_wdata = $urandom;
            end
        end
        idle(4);
        #2 chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
